// File: rtl/ollar_pkg.sv
// ollar_pkg: constants and types shared by the ollar pipeline and its memory responder.
// Latency: none, declarations only.
// Backpressure: not applicable.
package ollar_pkg;

    // Datapath word width, shared by the pipeline and the memory port.
    localparam int WORD_W = 32;

    // Bit positions of the status flags inside the processor status word.
    typedef enum int {
        FLAG_C = 0,
        FLAG_N = 1,
        FLAG_V = 2,
        FLAG_Z = 3
    } flag_idx_t;

    // Primary opcode field values.
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_LD  = 4'h6,
        OP_ST  = 4'h7,
        OP_BR  = 4'h8
    } opcode_t;

    // Memory responder state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/ollar_mem_responder_if.sv
// ollar_mem_responder_if: request/response bundle between the processor and the memory responder.
// Latency: none, wiring only.
// Backpressure: master holds Req until the slave pulses Ack.
interface ollar_mem_responder_if;
    import ollar_pkg::*;

    logic              Req;
    logic              Write;
    logic [WORD_W-1:0] Address;
    logic [WORD_W-1:0] DataIn;
    logic [WORD_W-1:0] DataOut;
    logic              Ack;
    logic              Err;

    modport master (
        output Req, Write, Address, DataIn,
        input  DataOut, Ack, Err
    );

    modport slave (
        input  Req, Write, Address, DataIn,
        output DataOut, Ack, Err
    );
endinterface

// File: rtl/ollar_mem_array.sv
// ollar_mem_array: single-port synchronous word RAM, one read or one write per cycle.
// Latency: read data is registered, valid the cycle after re; writes land on the same edge.
// Backpressure: none, accepts an access every cycle; rdata holds between reads.
module ollar_mem_array
    import ollar_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

    // Write wins the port; a read only updates rdata when requested.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ollar_mem_responder.sv
// ollar_mem_responder: memory slave FSM (IDLE/WAIT/RESP), wait counter, request latches; OLLAR_MEM_ERR_EN adds range checking.
// Latency: Ack pulses WAIT_STATES+1 cycles after the accepting edge; one IDLE cycle between back-to-back accesses.
// Backpressure: the processor holds Req until Ack; bus inputs are ignored between accept and Ack.
module ollar_mem_responder
    import ollar_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  Reset,
    ollar_mem_responder_if.slave  bus
);

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    resp_state_t           state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  wr_q;
    logic [WORD_W-1:0]     din_q;
    logic                  oor_q;
    logic                  ack_q;
    logic                  err_q;
    logic                  zero_q;
    logic                  oor_in;
    logic                  ram_we;
    logic                  ram_re;
    logic [WORD_W-1:0]     ram_rdata;

`ifdef OLLAR_MEM_ERR_EN
    // Any upper address bit set means the word is outside the array.
    assign oor_in  = |bus.Address[WORD_W-1:DEPTH_LOG2];
    assign bus.Err = err_q;
`else
    // Upper address bits are dropped, so addresses alias modulo the depth.
    logic unused_addr_hi;
    logic unused_err;
    assign oor_in         = 1'b0;
    assign unused_addr_hi = ^bus.Address[WORD_W-1:DEPTH_LOG2];
    assign unused_err     = err_q;
    assign bus.Err        = 1'b0;
`endif

    // The RAM is touched only in RESP; reset in that cycle cancels the access.
    assign ram_we = (state == RESP) && wr_q  && !oor_q && !Reset;
    assign ram_re = (state == RESP) && !wr_q && !oor_q && !Reset;

    ollar_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock (clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (idx_q),
        .wdata (din_q),
        .rdata (ram_rdata)
    );

    // zero_q masks the RAM read register after reset and out-of-range loads.
    assign bus.DataOut = zero_q ? '0 : ram_rdata;
    assign bus.Ack     = ack_q;

    // Request FSM: latch at accept, count wait states, pulse Ack from RESP.
    always_ff @(posedge clock) begin
        if (Reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Req) begin
                        idx_q <= bus.Address[DEPTH_LOG2-1:0];
                        wr_q  <= bus.Write;
                        din_q <= bus.DataIn;
                        oor_q <= oor_in;
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    ack_q <= 1'b1;
                    err_q <= oor_q;
                    if (!wr_q) begin
                        zero_q <= oor_q;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ollar_mem_responder.sv
// tb_ollar_mem_responder: three responders (WAIT_STATES 0, 1, 3) driven against a word-array reference model.
// Latency: expects Ack exactly WAIT_STATES+1 edges after the accept edge.
// Backpressure: Req is dropped after accept except in the back-to-back load burst.
module tb_ollar_mem_responder;

    localparam int DL = 10;
`ifdef OLLAR_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst  [3];
    logic        req  [3];
    logic        wr   [3];
    logic [31:0] addr [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic        ack  [3];
    logic        err  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        ollar_mem_responder_if b ();
        ollar_mem_responder #(
            .DEPTH_LOG2  (DL),
            .WAIT_STATES (WS)
        ) u_dut (
            .clock (clock),
            .Reset (rst[g]),
            .bus   (b)
        );
        assign b.Req     = req[g];
        assign b.Write   = wr[g];
        assign b.Address = addr[g];
        assign b.DataIn  = din[g];
        assign dout[g]   = b.DataOut;
        assign ack[g]    = b.Ack;
        assign err[g]    = b.Err;
    end

    // Reference model: one word array per responder plus the last load result.
    logic [31:0] mem_m    [3][2**DL];
    logic [31:0] exp_dout [3];

    int n_chk = 0;
    int n_err = 0;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    // One complete access; optional scrambling of the bus while it is in flight.
    task automatic do_access(input int d, input logic w, input logic [31:0] a,
                             input logic [31:0] di, input bit scramble,
                             output logic [31:0] o_dout, output logic o_err);
        int  lat;
        bit  oor;
        int  idx;
        lat = -1;
        idx = int'(a[DL-1:0]);
        oor = ERR_EN && (a[31:DL] != '0);
        @(negedge clock);
        req[d] = 1'b1; wr[d] = w; addr[d] = a; din[d] = di;
        @(posedge clock); #1;
        req[d] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (scramble) begin
                addr[d] = $urandom; din[d] = $urandom; wr[d] = 1'($urandom);
            end
            @(posedge clock); #1;
            if (ack[d]) begin
                lat = c;
                break;
            end
        end
        if (w) begin
            if (!oor) mem_m[d][idx] = di;
        end else begin
            exp_dout[d] = oor ? 32'h0 : mem_m[d][idx];
        end
        o_dout = dout[d];
        o_err  = err[d];
        chk($sformatf("d%0d ack_latency a=%h", d, a), lat, ws_of(d) + 1);
        chk($sformatf("d%0d dout a=%h w=%0d", d, a, w), dout[d], exp_dout[d]);
        chk($sformatf("d%0d err a=%h", d, a), err[d], oor);
        @(posedge clock); #1;
        chk($sformatf("d%0d ack_one_cycle", d), ack[d], 1'b0);
        chk($sformatf("d%0d dout_hold", d), dout[d], exp_dout[d]);
    endtask

    // Four loads at 0..3 with Req held high throughout.
    task automatic b2b_loads(input int d);
        int n;
        int cyc;
        int last;
        n = 0; cyc = 0; last = 0;
        @(negedge clock);
        req[d] = 1'b1; wr[d] = 1'b0; addr[d] = 32'd0;
        while (n < 4 && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            if (ack[d]) begin
                chk($sformatf("b2b dout[%0d]", n), dout[d], mem_m[d][n]);
                chk($sformatf("b2b spacing[%0d]", n), cyc - last, 2);
                exp_dout[d] = mem_m[d][n];
                last = cyc;
                n++;
                addr[d] = 32'(n);
                if (n == 4) req[d] = 1'b0;
            end
        end
        req[d] = 1'b0;
        chk("b2b ack_count", n, 4);
        @(posedge clock); #1;
    endtask

    // Store abandoned by a reset pulse k edges after accept.
    task automatic abort_store(input int d, input logic [31:0] a, input logic [31:0] di, input int k);
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        req[d] = 1'b1; wr[d] = 1'b1; addr[d] = a; din[d] = di;
        @(posedge clock); #1;
        req[d] = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(posedge clock); #1;
            if (ack[d]) seen = 1'b1;
        end
        @(negedge clock); rst[d] = 1'b1;
        @(negedge clock); rst[d] = 1'b0;
        exp_dout[d] = 32'h0;
        chk($sformatf("d%0d rst dout", d), dout[d], 32'h0);
        chk($sformatf("d%0d rst err", d), err[d], 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (ack[d]) seen = 1'b1;
        end
        chk($sformatf("d%0d abort no_ack", d), seen, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] od;
        logic        oe;
        logic [31:0] a;
        logic [31:0] old0;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = '0; din[d] = '0; exp_dout[d] = '0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d reset ack", d), ack[d], 1'b0);
            chk($sformatf("d%0d reset err", d), err[d], 1'b0);
            chk($sformatf("d%0d reset dout", d), dout[d], 32'h0);
            rst[d] = 1'b0;
        end

        // Known contents for words 0..15 of every instance.
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++)
                do_access(d, 1'b1, 32'(i), $urandom, 1'b0, od, oe);

        // Store then load at 0x10 with one wait state.
        do_access(1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, od, oe);
        chk("ws1 store dout_unchanged", od, 32'h0);
        do_access(1, 1'b0, 32'h10, 32'h0, 1'b0, od, oe);
        chk("ws1 load 0x10", od, 32'hDEADBEEF);
        chk("ws1 load err", oe, 1'b0);

        // Back-to-back loads with zero wait states.
        b2b_loads(0);

        // Reset during WAIT (ws=1) and during RESP (ws=3) drops the store.
        do_access(1, 1'b0, 32'd5, 32'h0, 1'b0, od, oe);
        abort_store(1, 32'd5, 32'h12345678, 0);
        do_access(1, 1'b0, 32'd5, 32'h0, 1'b0, od, oe);
        chk("abort wait old5", od, mem_m[1][5]);
        abort_store(2, 32'd6, ~mem_m[2][6], 3);
        do_access(2, 1'b0, 32'd6, 32'h0, 1'b0, od, oe);
        chk("abort resp old6", od, mem_m[2][6]);

        // Address 0x400: out of range with checking, alias of word 0 without.
        old0 = mem_m[1][0];
`ifdef OLLAR_MEM_ERR_EN
        do_access(1, 1'b1, 32'h400, 32'hAAAA5555, 1'b0, od, oe);
        chk("oor store err", oe, 1'b1);
        do_access(1, 1'b0, 32'h000, 32'h0, 1'b0, od, oe);
        chk("oor word0 unchanged", od, old0);
        do_access(1, 1'b0, 32'h400, 32'h0, 1'b0, od, oe);
        chk("oor load dout", od, 32'h0);
        chk("oor load err", oe, 1'b1);
`else
        do_access(1, 1'b1, 32'h400, 32'hCAFEF00D, 1'b0, od, oe);
        chk("alias store err", oe, 1'b0);
        do_access(1, 1'b0, 32'h000, 32'h0, 1'b0, od, oe);
        chk("alias word0", od, 32'hCAFEF00D);
        chk("alias load err", oe, 1'b0);
        chk("alias old differs", (old0 == 32'hCAFEF00D) ? 32'h1 : 32'h0, 32'h0);
`endif

        // Bus scrambled after accept with three wait states.
        do_access(2, 1'b1, 32'd9, 32'h0BADF00D, 1'b1, od, oe);
        do_access(2, 1'b0, 32'd9, 32'h0, 1'b1, od, oe);
        chk("scramble load 9", od, 32'h0BADF00D);

        // Random mixed traffic, occasionally with upper address bits set.
        for (int n = 0; n < 30; n++) begin
            for (int d = 0; d < 3; d++) begin
                a = 32'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) a[31:DL] = 22'($urandom | 1);
                do_access(d, 1'($urandom), a, $urandom, 1'($urandom), od, oe);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ollar_mem_responder.md
OLLAR_MEM_RESPONDER -- requirements
Module: ollar_mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: log2 of the number of 32-bit words stored.
REQ-002 Parameter WAIT_STATES, default 1, legal range 0..15: extra cycles inserted before each response.
REQ-003 clock  input  1  single clock; all logic updates on the rising edge only.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Req  input  1  access request from the processor; held high until Ack.
REQ-006 Write  input  1  1 = store, 0 = load; sampled with Req.
REQ-007 Address  input  32  word address from the processor.
REQ-008 DataIn  input  32  store data, driven from the processor's Output port.
REQ-009 DataOut  output  32  load data, driving the processor's Input port.
REQ-010 Ack  output  1  one-cycle completion pulse.
REQ-011 Err  output  1  out-of-range access flag, valid only with Ack.

Function
REQ-012 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-013 IDLE with Req=1 SHALL latch Address, Write and DataIn, then go to WAIT if WAIT_STATES>0, else to RESP.
REQ-014 WAIT SHALL load a 4-bit counter with WAIT_STATES-1 on entry, decrement it each cycle, and go to RESP when the counter is 0.
REQ-015 RESP SHALL assert Ack for exactly one cycle and then return to IDLE.
REQ-016 Ack SHALL rise WAIT_STATES+1 cycles after the accept edge.
REQ-017 Loads SHALL present the word at the latched address on DataOut in the Ack cycle.
REQ-018 DataOut SHALL hold that value until the next load's Ack cycle.
REQ-019 Stores SHALL commit the latched DataIn to the array in the RESP cycle.
REQ-020 After a store, DataOut SHALL remain unchanged.
REQ-021 Index SHALL be Address[DEPTH_LOG2-1:0]; Address changes after accept SHALL be ignored.
REQ-022 Req and Write changes after accept SHALL be ignored.
REQ-023 Req still high in the IDLE cycle after Ack SHALL be accepted as a new request, giving back-to-back accesses with one IDLE cycle between them.
REQ-024 A load from an address stored in the immediately preceding transaction SHALL return the new data.
REQ-025 Req=0 in IDLE SHALL leave all outputs and state unchanged.

Reset
REQ-026 Reset=1 SHALL force IDLE, counter=0, Ack=0, Err=0 and DataOut=0 on the next edge, with priority over every other input.
REQ-027 Reset asserted during WAIT or RESP SHALL abandon the transaction, and any pending store SHALL NOT commit.
REQ-028 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With OLLAR_MEM_ERR_EN defined, a request with any of Address[31:DEPTH_LOG2] nonzero SHALL complete with Ack=1 and Err=1.
REQ-030 With OLLAR_MEM_ERR_EN defined, an out-of-range store SHALL be suppressed, and an out-of-range load SHALL drive DataOut=0.
REQ-031 With OLLAR_MEM_ERR_EN defined, the out-of-range access SHALL take the same cycle latency as an in-range access.
REQ-032 Without OLLAR_MEM_ERR_EN, upper address bits SHALL be ignored (aliasing wrap-around), and Err SHALL be tied to 0.

Structure
REQ-033 Package ollar_pkg SHALL hold the word width (32), the status-bit indices C/N/V/Z, the opcode constants and the responder state encoding, shared with the processor pipeline.
REQ-034 The storage SHALL be a sub-module ollar_mem_array: synchronous single-port RAM, one read or write per cycle, registered read.
REQ-035 ollar_mem_responder SHALL contain only the FSM, the counter, the latches and the error logic.

Verification
REQ-036 WAIT_STATES=1: store 0xDEADBEEF to address 0x10, then load 0x10 -> store Ack 2 cycles after accept; load Ack 2 cycles after accept with DataOut=0xDEADBEEF and Err=0.
REQ-037 WAIT_STATES=0, Req held high across 4 loads at addresses 0..3 -> Ack every second cycle; DataOut matches each preloaded word in order.
REQ-038 Reset pulsed during WAIT of a store of 0x12345678 to address 5 -> Ack never rises; a subsequent load of address 5 returns the old value, and DataOut=0 directly after reset.
REQ-039 OLLAR_MEM_ERR_EN defined, DEPTH_LOG2=10, store 0xAAAA5555 to 0x400 -> Ack=1 and Err=1; a load of 0x000 is unchanged; a load of 0x400 returns DataOut=0 with Err=1.
REQ-040 OLLAR_MEM_ERR_EN undefined, store 0xCAFEF00D to 0x400 -> a load of 0x000 returns 0xCAFEF00D and Err is always 0.
REQ-041 Address and DataIn toggled randomly after accept during WAIT_STATES=3 -> the access uses the values latched at accept; Ack rises 4 cycles after accept.
